avg_filter: RTL and testbench

Stereo moving-average (boxcar) noise-reduction stage placed between the audio CODEC read port and write port. It accepts one left/right 24-bit sample pair per handshake, keeps the last N pairs in a circular buffer, and outputs the running mean of each channel. A bypass input passes samples through unchanged while the history keeps updating, so toggling the filter causes no transient. The control unit drives `in_valid` from `read_ready` and pulls `out_ready` from `write_ready`.

---
 rtl/avg_filter.sv | 80 ++++++++
 tb/tb_avg_filter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_filter.sv
// rtl/avg_filter.sv - stereo boxcar moving-average filter with bypass
module avg_filter #(
    parameter int N     = 8,
    parameter int LOG2N = 3
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               filter_on,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [23:0] in_left,
    input  logic signed [23:0] in_right,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [23:0] out_left,
    output logic signed [23:0] out_right
);

    // Sums carry LOG2N guard bits so N full-scale samples never overflow.
    localparam int SW = 24 + LOG2N;

    logic signed [23:0]  buf_l [N];
    logic signed [23:0]  buf_r [N];
    logic [LOG2N-1:0]    wr_ptr;
    logic signed [SW-1:0] sum_l;
    logic signed [SW-1:0] sum_r;
    logic signed [SW-1:0] sum_l_next;
    logic signed [SW-1:0] sum_r_next;
    logic                accept;

    // The output register may be refilled in the same cycle it is drained.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Running sums: drop the oldest entry, add the newest, both sign-extended.
    always_comb begin
        sum_l_next = sum_l - {{LOG2N{buf_l[wr_ptr][23]}}, buf_l[wr_ptr]}
                           + {{LOG2N{in_left[23]}}, in_left};
        sum_r_next = sum_r - {{LOG2N{buf_r[wr_ptr][23]}}, buf_r[wr_ptr]}
                           + {{LOG2N{in_right[23]}}, in_right};
    end

    // History buffer, sums and write pointer advance on every accept,
    // regardless of bypass, so toggling filter_on causes no transient.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                buf_l[i] <= '0;
                buf_r[i] <= '0;
            end
            sum_l  <= '0;
            sum_r  <= '0;
            wr_ptr <= '0;
        end else if (accept) begin
            buf_l[wr_ptr] <= in_left;
            buf_r[wr_ptr] <= in_right;
            sum_l         <= sum_l_next;
            sum_r         <= sum_r_next;
            // N is a power of two, so the natural wrap of wr_ptr is the ring wrap.
            wr_ptr        <= wr_ptr + LOG2N'(1);
        end
    end

    // Output register: load on accept, release on transfer, hold while stalled.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            // Dropping the low LOG2N bits is an arithmetic shift: floor division.
            out_left  <= filter_on ? sum_l_next[SW-1:LOG2N] : in_left;
            out_right <= filter_on ? sum_r_next[SW-1:LOG2N] : in_right;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_avg_filter.sv
// tb/tb_avg_filter.sv - scoreboard testbench for avg_filter
module tb_avg_filter;

    logic               clk;
    logic               reset_n;
    logic               filter_on;
    logic               in_valid;
    logic               in_ready;
    logic signed [23:0] in_left;
    logic signed [23:0] in_right;
    logic               out_valid;
    logic               out_ready;
    logic signed [23:0] out_left;
    logic signed [23:0] out_right;

    int checks;
    int failures;

    logic [47:0] sb_q[$];

    longint m_buf_l[8];
    longint m_buf_r[8];
    int     m_ptr;
    longint m_sum_l;
    longint m_sum_r;

    avg_filter #(.N(8), .LOG2N(3)) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .filter_on(filter_on),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_left  (in_left),
        .in_right (in_right),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_left (out_left),
        .out_right(out_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_buf_l[i] = 0;
            m_buf_r[i] = 0;
        end
        m_ptr   = 0;
        m_sum_l = 0;
        m_sum_r = 0;
    endtask

    task automatic model_accept(input logic signed [23:0] l, input logic signed [23:0] r);
        longint      sl;
        longint      sr;
        logic [23:0] el;
        logic [23:0] er;
        sl = m_sum_l - m_buf_l[m_ptr] + longint'(l);
        sr = m_sum_r - m_buf_r[m_ptr] + longint'(r);
        m_buf_l[m_ptr] = longint'(l);
        m_buf_r[m_ptr] = longint'(r);
        m_sum_l = sl;
        m_sum_r = sr;
        m_ptr   = (m_ptr + 1) % 8;
        el = filter_on ? 24'(sl >>> 3) : l;
        er = filter_on ? 24'(sr >>> 3) : r;
        sb_q.push_back({el, er});
    endtask

    task automatic send(input logic signed [23:0] l, input logic signed [23:0] r);
        int budget;
        budget   = 0;
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && budget < 100) begin
            budget++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send_timeout", 24'(in_ready), 24'd1);
            in_valid = 1'b0;
        end else begin
            model_accept(l, r);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("latency_valid", 24'(out_valid), 24'd1);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb_q.size() != 0 && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_timeout", 24'(sb_q.size()), 24'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #2;
        check("rst_out_valid", 24'(out_valid), 24'd0);
        check("rst_out_left", out_left, 24'd0);
        check("rst_out_right", out_right, 24'd0);
        sb_q.delete();
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_in_ready", 24'(in_ready), 24'd1);
    endtask

    // Scoreboard monitor: every transfer pops exactly one expected pair.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 24'(sb_q.size()), 24'd1);
            end else begin
                logic [47:0] e;
                e = sb_q.pop_front();
                check("out_left", out_left, e[47:24]);
                check("out_right", out_right, e[23:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        filter_on = 1'b1;
        in_valid  = 1'b0;
        in_left   = '0;
        in_right  = '0;
        out_ready = 1'b1;
        model_clear();
        #3;
        check("init_out_valid", 24'(out_valid), 24'd0);
        check("init_out_left", out_left, 24'd0);
        check("init_out_right", out_right, 24'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("init_in_ready", 24'(in_ready), 24'd1);

        // Step response
        for (int i = 0; i < 10; i++) send(24'sd800, 24'sd800);
        drain();
        check("step_final", out_left, 24'd800);

        // Signed rounding and pointer wrap
        do_reset();
        send(-24'sd8, 24'sd8);
        for (int i = 0; i < 7; i++) send(24'sd0, 24'sd0);
        drain();
        check("neg8_hold", out_left, 24'hFFFFFF);
        send(24'sd0, 24'sd0);
        drain();
        check("wrap_zero", out_left, 24'd0);
        do_reset();
        send(24'sd7, -24'sd7);
        drain();
        check("seven_floor", out_left, 24'd0);
        do_reset();
        send(-24'sd1, 24'sd1);
        drain();
        check("minus1_floor", out_left, 24'hFFFFFF);

        // Full scale
        do_reset();
        for (int i = 0; i < 8; i++) send(24'sh7FFFFF, 24'sh800000);
        drain();
        check("fs_pos_left", out_left, 24'h7FFFFF);
        check("fs_neg_right", out_right, 24'h800000);
        for (int i = 0; i < 8; i++) send(24'sh800000, 24'sh7FFFFF);
        drain();
        check("fs_neg_left", out_left, 24'h800000);
        check("fs_pos_right", out_right, 24'h7FFFFF);

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        in_left   = 24'sd16;
        in_right  = 24'sd16;
        in_valid  = 1'b1;
        @(negedge clk);
        check("bp_first_ready", 24'(in_ready), 24'd1);
        model_accept(24'sd16, 24'sd16);
        @(posedge clk);
        #1;
        in_left  = 24'sd32;
        in_right = 24'sd32;
        check("bp_latency", 24'(out_valid), 24'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_stall_ready", 24'(in_ready), 24'd0);
            check("bp_hold_left", out_left, 24'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_ready", 24'(in_ready), 24'd1);
        model_accept(24'sd32, 24'sd32);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_left", out_left, 24'd6);
        send(24'sd48, 24'sd48);
        send(24'sd64, 24'sd64);
        drain();

        // Bypass toggle
        do_reset();
        for (int i = 0; i < 8; i++) send(24'sd400, 24'sd400);
        filter_on = 1'b0;
        send(24'sd1000, 24'sd1000);
        drain();
        check("bypass_left", out_left, 24'd1000);
        filter_on = 1'b1;
        send(24'sd1000, 24'sd1000);
        drain();
        check("rejoin_left", out_left, 24'd550);

        // Random traffic
        for (int i = 0; i < 30; i++) begin
            send(24'($urandom), 24'($urandom));
        end
        drain();

        // Reset mid-stream
        out_ready = 1'b0;
        send(24'sd123, -24'sd5);
        check("mid_pending", 24'(out_valid), 24'd1);
        do_reset();
        out_ready = 1'b1;
        send(24'sd80, 24'sd80);
        drain();
        check("post_reset_left", out_left, 24'd10);
        check("post_reset_right", out_right, 24'd10);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
